// File: rtl/uart_rx_ext.sv
// Parametrised oversampled UART receiver with parity/framing/break/overrun detection
// and a valid/ready output holding register. Define UART_RX_MAJORITY_EN for 3-sample voting.
module uart_rx_ext #(
   parameter int DBIT       = 8,
   parameter int OVERSAMPLE = 16,
   parameter int SB_TICK    = 16,
   parameter int PARITY     = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   input  logic            s_tick,
   output logic [DBIT-1:0] dout,
   output logic            dout_valid,
   input  logic            dout_ready,
   output logic            parity_err,
   output logic            frame_err,
   output logic            break_det,
   output logic            overrun_err,
   output logic            rx_done_tick
);

   localparam int TMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
   localparam int TW   = $clog2(TMAX);
   localparam int BW   = ($clog2(DBIT) < 1) ? 1 : $clog2(DBIT);

   localparam logic [TW-1:0] START_LAST = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] BIT_LAST   = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] STOP_LAST  = TW'(SB_TICK - 1);
   localparam logic [BW-1:0] DBIT_LAST  = BW'(DBIT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PAR,
      ST_STOP
   } state_t;

   state_t          state;
   logic [TW-1:0]   tick_cnt;
   logic [BW-1:0]   bit_cnt;
   logic [DBIT-1:0] shreg;
   logic            par_bit;
   logic            par_bad;
   logic            samp;

`ifdef UART_RX_MAJORITY_EN
   // Two previous s_tick samples; with the current rx they form the vote window.
   logic [1:0] hist;

   always_ff @(posedge clk) begin
      if (reset) begin
         hist <= 2'b11;
      end else if (s_tick) begin
         hist <= {hist[0], rx};
      end
   end

   assign samp = (hist[1] & hist[0]) | (hist[1] & rx) | (hist[0] & rx);
`else
   assign samp = rx;
`endif

   // Holding register handshake: a word transfers on any clk where dout_valid and
   // dout_ready are both high. A completing frame may refill the register in that
   // same clk; if the register is full and not being drained, the frame is dropped
   // and overrun_err pulses. dout and flags only change when a word is loaded.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         tick_cnt     <= '0;
         bit_cnt      <= '0;
         shreg        <= '0;
         par_bit      <= 1'b0;
         par_bad      <= 1'b0;
         dout         <= '0;
         dout_valid   <= 1'b0;
         parity_err   <= 1'b0;
         frame_err    <= 1'b0;
         break_det    <= 1'b0;
         overrun_err  <= 1'b0;
         rx_done_tick <= 1'b0;
      end else begin
         rx_done_tick <= 1'b0;
         overrun_err  <= 1'b0;
         if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (!rx) begin
                  state    <= ST_START;
                  tick_cnt <= '0;
               end
            end

            ST_START: begin
               if (s_tick) begin
                  if (tick_cnt == START_LAST) begin
                     if (samp) begin
                        state <= ST_IDLE;
                     end else begin
                        state    <= ST_DATA;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end

            ST_DATA: begin
               if (s_tick) begin
                  if (tick_cnt == BIT_LAST) begin
                     tick_cnt <= '0;
                     shreg    <= {samp, shreg[DBIT-1:1]};
                     if (bit_cnt == DBIT_LAST) begin
                        state <= (PARITY != 0) ? ST_PAR : ST_STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end

            ST_PAR: begin
               if (s_tick) begin
                  if (tick_cnt == BIT_LAST) begin
                     par_bit  <= samp;
                     par_bad  <= (^shreg) ^ samp ^ (PARITY == 2);
                     state    <= ST_STOP;
                     tick_cnt <= '0;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end

            ST_STOP: begin
               if (s_tick) begin
                  if (tick_cnt == STOP_LAST) begin
                     state        <= ST_IDLE;
                     tick_cnt     <= '0;
                     rx_done_tick <= 1'b1;
                     if (!dout_valid || dout_ready) begin
                        dout       <= shreg;
                        dout_valid <= 1'b1;
                        frame_err  <= ~samp;
                        parity_err <= (PARITY != 0) && par_bad;
                        break_det  <= ~samp && (shreg == '0) && ((PARITY == 0) || !par_bit);
                     end else begin
                        overrun_err <= 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end

            default: begin
               state    <= ST_IDLE;
               tick_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_rx_ext.md
Name:
uart_rx_ext

Overview:
Parametrised UART receiver, successor to the basic 8N1 receiver.
- Oversampled by an external baud-tick generator (`s_tick`).
- Data width, oversample factor, stop length and parity mode are configurable.
- Rejects false start bits and detects parity, framing, break and overrun conditions.
- Presents each received word through a valid/ready holding register, so downstream logic (FIFO, bus bridge) can apply backpressure.

Parameters:
- DBIT, 8, data bits per frame, legal range 5..9.
- OVERSAMPLE, 16, s_tick periods per bit; even, >= 8.
- SB_TICK, 16, s_tick periods for the stop field (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- rx  in  1  serial input, idle high
- s_tick  in  1  one-clk oversample strobe, OVERSAMPLE pulses per bit
- dout  out  DBIT  received word, LSB first on the line
- dout_valid  out  1  dout and flags hold an unconsumed word
- dout_ready  in  1  consumer accepts the word when high with dout_valid
- parity_err  out  1  parity mismatch for the held word; 0 when PARITY=0
- frame_err  out  1  stop sample was 0 for the held word
- break_det  out  1  held word is a break: all data, parity and stop samples 0
- overrun_err  out  1  one-clk pulse; a completed word was dropped
- rx_done_tick  out  1  one-clk pulse at each frame completion, including dropped frames

Behaviour:
Reset:
- State idle; all counters 0; shift register 0.
- dout=0, dout_valid=0, all error flags 0.
- Reset mid-frame aborts the frame with no completion and no pulses.

Counter widths:
- Tick counter is clog2(max(OVERSAMPLE,SB_TICK)) bits.
- Bit counter is clog2(DBIT) bits, minimum 1.
- Counters advance only on s_tick; the FSM holds between ticks.

FSM states: idle, start, data, par, stop.
- idle: rx==0 -> start, tick counter = 0. The check does not require s_tick.
- start: on the s_tick with count == OVERSAMPLE/2-1, sample rx.
  - rx==1 -> false start, return to idle; no pulses, no flags.
  - rx==0 -> data, tick counter = 0, bit counter = 0.
- data: on the s_tick with count == OVERSAMPLE-1, sample rx, shift it in at the MSB (shift right), reset count.
  - After bit DBIT-1: go to par if PARITY != 0, else go to stop.
- par: sample at count == OVERSAMPLE-1.
  - Computed error = XOR of data bits and parity sample, inverted for odd mode.
  - Then go to stop, count = 0.
- stop: sample rx at count == SB_TICK-1.
  - Frame completes; go to idle. The next frame may start on the following clk if rx==0.
  - frame_err = (sample == 0).
  - break_det = frame_err AND all data bits 0 AND parity sample 0 (or no parity).
- A sustained break yields repeated frames with frame_err=1.

Completion (same clk as the final stop sample):
- rx_done_tick = 1.
- If dout_valid == 0, or dout_valid && dout_ready in this clk:
  - Load dout and the three flags; dout_valid = 1.
- Else:
  - Word dropped; holding register unchanged; overrun_err = 1 for one clk.

Handshake:
- dout_valid && dout_ready with no completion in that clk -> dout_valid = 0 next clk.
- dout and flags stay stable while dout_valid = 1 and not accepted.
- Flags are qualified by dout_valid; they retain their value after acceptance.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined:
  - Each start check, data, parity and stop decision uses the majority of three rx samples.
  - The samples are taken on the last three s_ticks ending at the normal sample tick.
  - A single-tick glitch is therefore ignored.
  - Adds a 2-bit sample history; timing of state transitions is unchanged.
- Undefined: single sample at the stated tick, as above.

Test Plan:
1. 8N1, ready=1, send 0xA5 -> dout=0xA5, dout_valid high one clk, all flags 0, rx_done_tick one pulse.
2. PARITY=1, send 0x03 with parity bit 1 -> parity_err=1; repeat with parity bit 0 -> parity_err=0.
   - With PARITY=2, parity bit 1 -> parity_err=0.
3. Stop bit driven 0 on 0x55 -> frame_err=1, break_det=0.
   - All-zero frame with stop 0 -> frame_err=1, break_det=1.
4. rx low for 4 s_ticks then high (OVERSAMPLE=16) -> FSM back in idle, no rx_done_tick, dout_valid stays 0.
5. ready=0, send 0x11 then 0x22 -> dout=0x11 held, overrun_err one pulse at second completion.
   - Raise ready on the same clk as a third completion (0x33) -> dout=0x33, dout_valid stays 1.
6. Assert reset mid data bit 4 -> no completion; next frame 0x7E received correctly.
   - With UART_RX_MAJORITY_EN: one-tick low glitch at mid-bit of 0xFF -> dout=0xFF.
